flag_branch_unit: RTL and testbench

Consumes the ALU's per-opcode Z/V/N flag output and resolves conditional branches for the 16-bit core. Holds the architectural FLAG register with per-opcode selective update. Evaluates the 3-bit branch condition against current or in-flight flags. Issues a registered one-cycle PC redirect and squashes the wrong-path slot behind it. Sits between the EX stage (ALU output) and the fetch PC mux.

---
 rtl/flag_branch_unit_if.sv | 32 +++
 rtl/flag_branch_unit.sv | 102 ++++++++++
 tb/tb_flag_branch_unit.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/flag_branch_unit_if.sv
// Bundle between the EX stage / branch requester and flag_branch_unit.
// master = requester (drives ALU result and branch request), slave = the unit.
interface flag_branch_unit_if #(
    parameter int PC_W = 16
);
    logic            freeze;
    logic            alu_valid;
    logic [2:0]      alu_opcode;
    logic [2:0]      alu_flags;
    logic            br_valid;
    logic [2:0]      br_cond;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] br_pc_plus2;
    logic [2:0]      flags;
    logic            br_stall;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            br_taken;
    logic            squash;

    modport master (
        output freeze, alu_valid, alu_opcode, alu_flags,
        output br_valid, br_cond, br_target, br_pc_plus2,
        input  flags, br_stall, redirect, redirect_pc, br_taken, squash
    );

    modport slave (
        input  freeze, alu_valid, alu_opcode, alu_flags,
        input  br_valid, br_cond, br_target, br_pc_plus2,
        output flags, br_stall, redirect, redirect_pc, br_taken, squash
    );
endinterface

// File: rtl/flag_branch_unit.sv
// Architectural Z/V/N flag register plus conditional branch resolution with a registered redirect.
// Define FLAG_BYPASS_EN to forward same-cycle ALU flags into branch evaluation instead of stalling.
module flag_branch_unit #(
    parameter int PC_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    flag_branch_unit_if.slave  bus
);

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_XOR    = 3'b010;
    localparam logic [2:0] OP_SLL    = 3'b100;
    localparam logic [2:0] OP_SRA    = 3'b101;
    localparam logic [2:0] OP_ROR    = 3'b110;

    // Which of {Z,V,N} an opcode is allowed to write.
    function automatic logic [2:0] flag_mask(input logic [2:0] op);
        case (op)
            OP_ADD, OP_SUB:                 flag_mask = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_mask = 3'b100;
            default:                        flag_mask = 3'b000;
        endcase
    endfunction

    function automatic logic cond_eval(input logic [2:0] cond, input logic [2:0] f);
        logic z, v, n;
        z = f[2];
        v = f[1];
        n = f[0];
        case (cond)
            3'b000:  cond_eval = !z;
            3'b001:  cond_eval = z;
            3'b010:  cond_eval = !z && !n;
            3'b011:  cond_eval = n;
            3'b100:  cond_eval = z || !n;
            3'b101:  cond_eval = n || z;
            3'b110:  cond_eval = v;
            default: cond_eval = 1'b1;
        endcase
    endfunction

    logic [2:0]      flags_q;
    logic            redirect_p1;
    logic            taken_p1;
    logic [PC_W-1:0] redirect_pc_p1;
    logic            squash_p1;

    logic [2:0]      mask;
    logic [2:0]      merged_flags;
    logic [2:0]      eval_flags;
    logic            flag_wr;
    logic            stall;
    logic            accept;
    logic            cond_taken;

    always_comb begin
        mask         = flag_mask(bus.alu_opcode);
        flag_wr      = bus.alu_valid && !bus.freeze && !squash_p1 && (mask != 3'b000);
        merged_flags = (flags_q & ~mask) | (bus.alu_flags & mask);
`ifdef FLAG_BYPASS_EN
        eval_flags   = flag_wr ? merged_flags : flags_q;
        stall        = 1'b0;
`else
        // No forwarding: a branch meeting a flag write waits for the registered result.
        eval_flags   = flags_q;
        stall        = bus.br_valid && flag_wr;
`endif
        accept       = bus.br_valid && !bus.freeze && !squash_p1 && !stall;
        cond_taken   = cond_eval(bus.br_cond, eval_flags);
    end

    // Stage p1: registered flags, redirect and the one-slot squash behind a taken redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q        <= 3'b000;
            redirect_p1    <= 1'b0;
            taken_p1       <= 1'b0;
            redirect_pc_p1 <= '0;
            squash_p1      <= 1'b0;
        end else if (!bus.freeze) begin
            if (flag_wr) begin
                flags_q <= merged_flags;
            end
            redirect_p1 <= accept;
            squash_p1   <= redirect_p1 && taken_p1;
            if (accept) begin
                taken_p1       <= cond_taken;
                redirect_pc_p1 <= cond_taken ? bus.br_target : bus.br_pc_plus2;
            end
        end
    end

    assign bus.flags       = flags_q;
    assign bus.br_stall    = stall;
    assign bus.redirect    = redirect_p1;
    assign bus.br_taken    = taken_p1;
    assign bus.redirect_pc = redirect_pc_p1;
    assign bus.squash      = squash_p1;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench for flag_branch_unit: directed vector table, reset corner sequences, random run vs reference model.
module tb_flag_branch_unit;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    flag_branch_unit_if #(.PC_W(16)) bus();

    flag_branch_unit #(.PC_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FLAG_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        logic        frz;
        logic        av;
        logic [2:0]  op;
        logic [2:0]  af;
        logic        bv;
        logic [2:0]  cond;
        logic [15:0] tgt;
        logic [15:0] pc2;
        logic [2:0]  e_flags;
        logic        e_stall;
        logic        e_redir;
        logic        e_taken;
        logic [15:0] e_pc;
        logic        e_sq;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic frz, logic av, logic [2:0] op, logic [2:0] af,
                                logic bv, logic [2:0] cond, logic [15:0] tgt, logic [15:0] pc2,
                                logic [2:0] e_flags, logic e_stall, logic e_redir,
                                logic e_taken, logic [15:0] e_pc, logic e_sq);
        vec_t v;
        v.frz = frz; v.av = av; v.op = op; v.af = af; v.bv = bv; v.cond = cond;
        v.tgt = tgt; v.pc2 = pc2; v.e_flags = e_flags; v.e_stall = e_stall;
        v.e_redir = e_redir; v.e_taken = e_taken; v.e_pc = e_pc; v.e_sq = e_sq;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic frz, input logic av, input logic [2:0] op, input logic [2:0] af,
                         input logic bv, input logic [2:0] cond, input logic [15:0] tgt,
                         input logic [15:0] pc2);
        bus.freeze      = frz;
        bus.alu_valid   = av;
        bus.alu_opcode  = op;
        bus.alu_flags   = af;
        bus.br_valid    = bv;
        bus.br_cond     = cond;
        bus.br_target   = tgt;
        bus.br_pc_plus2 = pc2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0, 16'h0);
    endtask

    // Reference model: architectural state as the spec describes it.
    logic [2:0]  m_flags;
    logic        m_redir, m_taken, m_sq;
    logic [15:0] m_pc;

    function automatic logic [2:0] writable(input logic [2:0] op);
        if (op == 3'd0 || op == 3'd1) return 3'b111;                        // ADD, SUB
        if (op == 3'd2 || op == 3'd4 || op == 3'd5 || op == 3'd6) return 3'b100;
        return 3'b000;                                                      // RED, PADSUB
    endfunction

    function automatic logic branch_goes(input logic [2:0] cond, input logic [2:0] f);
        logic z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (cond)
            3'd0: return z == 1'b0;
            3'd1: return z == 1'b1;
            3'd2: return z == 1'b0 && n == 1'b0;
            3'd3: return n == 1'b1;
            3'd4: return z == 1'b1 || (z == 1'b0 && n == 1'b0);
            3'd5: return n == 1'b1 || z == 1'b1;
            3'd6: return v == 1'b1;
            default: return 1'b1;
        endcase
    endfunction

    initial begin
        logic        hold_br;
        logic        r_bv;
        logic [2:0]  r_cond;
        logic [15:0] r_tgt, r_pc2;
        pass_cnt  = 0;
        total_cnt = 0;
        idle();
        rst = 1'b1;

        // Directed vectors: expectations are the outputs after the clock edge of that row.
        vecs.push_back(mk(0,1,3'd0,3'b101, 0,3'd0,16'h0,16'h0,    3'b101,0,0,0,16'h0,0)); // ADD
        vecs.push_back(mk(0,1,3'd2,3'b010, 0,3'd0,16'h0,16'h0,    3'b001,0,0,0,16'h0,0)); // XOR: Z only
        vecs.push_back(mk(0,1,3'd0,3'b000, 0,3'd0,16'h0,16'h0,    3'b000,0,0,0,16'h0,0));
        vecs.push_back(mk(0,1,3'd3,3'b111, 0,3'd0,16'h0,16'h0,    3'b000,0,0,0,16'h0,0)); // RED
        vecs.push_back(mk(0,1,3'd5,3'b100, 0,3'd0,16'h0,16'h0,    3'b100,0,0,0,16'h0,0)); // SRA
        vecs.push_back(mk(0,1,3'd0,3'b001, 0,3'd0,16'h0,16'h0,    3'b001,0,0,0,16'h0,0));
        vecs.push_back(mk(0,0,3'd0,3'b000, 1,3'd3,16'h0040,16'h0012, 3'b001,0,1,1,16'h0040,0)); // LT
        vecs.push_back(mk(0,0,3'd0,3'b000, 0,3'd0,16'h0,16'h0,    3'b001,0,0,0,16'h0,1));
        vecs.push_back(mk(0,1,3'd1,3'b110, 1,3'd7,16'h0abc,16'h0002, 3'b001,0,0,0,16'h0,0)); // squashed
        vecs.push_back(mk(0,1,3'd0,3'b000, 0,3'd0,16'h0,16'h0,    3'b000,0,0,0,16'h0,0));
        if (BYPASS) begin
            vecs.push_back(mk(0,1,3'd1,3'b100, 1,3'd1,16'h0100,16'h0020, 3'b100,0,1,1,16'h0100,0));
            vecs.push_back(mk(0,0,3'd0,3'b000, 0,3'd0,16'h0,16'h0,    3'b100,0,0,0,16'h0,1));
            vecs.push_back(mk(0,0,3'd0,3'b000, 0,3'd0,16'h0,16'h0,    3'b100,0,0,0,16'h0,0));
        end else begin
            vecs.push_back(mk(0,1,3'd1,3'b100, 1,3'd1,16'h0100,16'h0020, 3'b100,1,0,0,16'h0,0));
            vecs.push_back(mk(0,0,3'd0,3'b000, 1,3'd1,16'h0100,16'h0020, 3'b100,0,1,1,16'h0100,0));
            vecs.push_back(mk(0,0,3'd0,3'b000, 0,3'd0,16'h0,16'h0,    3'b100,0,0,0,16'h0,1));
            vecs.push_back(mk(0,0,3'd0,3'b000, 0,3'd0,16'h0,16'h0,    3'b100,0,0,0,16'h0,0));
        end
        vecs.push_back(mk(0,1,3'd0,3'b010, 0,3'd0,16'h0,16'h0,    3'b010,0,0,0,16'h0,0));
        vecs.push_back(mk(0,0,3'd0,3'b000, 1,3'd6,16'h0200,16'h0030, 3'b010,0,1,1,16'h0200,0)); // OVFL
        vecs.push_back(mk(0,0,3'd0,3'b000, 0,3'd0,16'h0,16'h0,    3'b010,0,0,0,16'h0,1));
        vecs.push_back(mk(0,0,3'd0,3'b000, 0,3'd0,16'h0,16'h0,    3'b010,0,0,0,16'h0,0));
        vecs.push_back(mk(0,1,3'd0,3'b100, 0,3'd0,16'h0,16'h0,    3'b100,0,0,0,16'h0,0));
        vecs.push_back(mk(0,1,3'd3,3'b000, 1,3'd0,16'h0300,16'h0040, 3'b100,0,1,0,16'h0040,0)); // NEQ+RED
        vecs.push_back(mk(0,0,3'd0,3'b000, 1,3'd0,16'h0310,16'h0050, 3'b100,0,1,0,16'h0050,0)); // back-to-back
        vecs.push_back(mk(0,0,3'd0,3'b000, 0,3'd0,16'h0,16'h0,    3'b100,0,0,0,16'h0,0));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1,1,3'd0,3'b111, 1,3'd7,16'h0400,16'h0060, 3'b100,0,0,0,16'h0,0)); // freeze
        vecs.push_back(mk(0,0,3'd0,3'b000, 1,3'd7,16'h0400,16'h0060, 3'b100,0,1,1,16'h0400,0));
        vecs.push_back(mk(0,0,3'd0,3'b000, 0,3'd0,16'h0,16'h0,    3'b100,0,0,0,16'h0,1));
        for (int k = 0; k < 2; k++)
            vecs.push_back(mk(1,1,3'd0,3'b111, 0,3'd0,16'h0,16'h0, 3'b100,0,0,0,16'h0,1)); // squash held
        vecs.push_back(mk(0,1,3'd0,3'b111, 0,3'd0,16'h0,16'h0,    3'b100,0,0,0,16'h0,0));
        vecs.push_back(mk(0,1,3'd0,3'b111, 0,3'd0,16'h0,16'h0,    3'b111,0,0,0,16'h0,0));

        repeat (2) @(posedge clk);
        #1;
        check("rst_flags", {13'd0, bus.flags}, 16'h0);
        check("rst_redirect", {15'd0, bus.redirect}, 16'h0);
        check("rst_taken", {15'd0, bus.br_taken}, 16'h0);
        check("rst_pc", bus.redirect_pc, 16'h0);
        check("rst_squash", {15'd0, bus.squash}, 16'h0);
        check("rst_stall", {15'd0, bus.br_stall}, 16'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].frz, vecs[i].av, vecs[i].op, vecs[i].af,
                  vecs[i].bv, vecs[i].cond, vecs[i].tgt, vecs[i].pc2);
            #1;
            check($sformatf("vec%0d_stall", i), {15'd0, bus.br_stall}, {15'd0, vecs[i].e_stall});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_flags", i), {13'd0, bus.flags}, {13'd0, vecs[i].e_flags});
            check($sformatf("vec%0d_redirect", i), {15'd0, bus.redirect}, {15'd0, vecs[i].e_redir});
            check($sformatf("vec%0d_squash", i), {15'd0, bus.squash}, {15'd0, vecs[i].e_sq});
            if (vecs[i].e_redir) begin
                check($sformatf("vec%0d_taken", i), {15'd0, bus.br_taken}, {15'd0, vecs[i].e_taken});
                check($sformatf("vec%0d_pc", i), bus.redirect_pc, vecs[i].e_pc);
            end
        end

        // Reset during a stall (or, with bypass, during an accepting cycle): nothing survives.
        @(negedge clk);
        drive(1'b0, 1'b1, 3'd1, 3'b111, 1'b1, 3'd7, 16'h0500, 16'h0070);
        #1;
        check("stall_pre_rst", {15'd0, bus.br_stall}, BYPASS ? 16'h0 : 16'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_stall_flags", {13'd0, bus.flags}, 16'h0);
        check("rst_stall_redirect", {15'd0, bus.redirect}, 16'h0);
        check("rst_stall_pc", bus.redirect_pc, 16'h0);
        @(negedge clk);
        idle();
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_redirect", {15'd0, bus.redirect}, 16'h0);

        // Reset while a taken redirect is out: the squash it would cause never appears.
        @(negedge clk);
        drive(1'b0, 1'b0, 3'd0, 3'd0, 1'b1, 3'd7, 16'h0600, 16'h0080);
        @(posedge clk);
        #1;
        check("pre_rst_redirect", {15'd0, bus.redirect}, 16'h1);
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_sq_squash", {15'd0, bus.squash}, 16'h0);
        check("rst_sq_redirect", {15'd0, bus.redirect}, 16'h0);
        check("rst_sq_taken", {15'd0, bus.br_taken}, 16'h0);
        @(negedge clk);
        rst = 1'b0;

        // Random run against the model.
        m_flags = 3'b000; m_redir = 1'b0; m_taken = 1'b0; m_sq = 1'b0; m_pc = 16'h0;
        hold_br = 1'b0;
        r_bv = 1'b0; r_cond = 3'd0; r_tgt = 16'h0; r_pc2 = 16'h0;
        for (int c = 0; c < 400; c++) begin
            logic        frz, av, ignore, writes, stall_e, acc, take;
            logic [2:0]  op, af, wm, nflags, seen;
            @(negedge clk);
            frz = ($urandom_range(0, 7) == 0);
            av  = $urandom_range(0, 1);
            op  = 3'($urandom_range(0, 7));
            af  = 3'($urandom_range(0, 7));
            if (!hold_br) begin
                r_bv   = ($urandom_range(0, 2) == 0);
                r_cond = 3'($urandom_range(0, 7));
                r_tgt  = 16'($urandom);
                r_pc2  = 16'($urandom);
            end
            drive(frz, av, op, af, r_bv, r_cond, r_tgt, r_pc2);

            ignore  = frz || m_sq;
            wm      = writable(op);
            writes  = av && !ignore && (wm != 3'b000);
            nflags  = writes ? ((m_flags & ~wm) | (af & wm)) : m_flags;
            seen    = BYPASS ? nflags : m_flags;
            stall_e = !BYPASS && r_bv && writes;
            acc     = r_bv && !ignore && !stall_e;
            take    = branch_goes(r_cond, seen);
            hold_br = stall_e;
            #1;
            check("rnd_stall", {15'd0, bus.br_stall}, {15'd0, stall_e});
            if (!frz) begin
                m_sq    = m_redir && m_taken;
                m_redir = acc;
                if (acc) begin
                    m_taken = take;
                    m_pc    = take ? r_tgt : r_pc2;
                end
                m_flags = nflags;
            end
            @(posedge clk);
            #1;
            check("rnd_flags", {13'd0, bus.flags}, {13'd0, m_flags});
            check("rnd_redirect", {15'd0, bus.redirect}, {15'd0, m_redir});
            check("rnd_squash", {15'd0, bus.squash}, {15'd0, m_sq});
            if (m_redir) begin
                check("rnd_taken", {15'd0, bus.br_taken}, {15'd0, m_taken});
                check("rnd_pc", bus.redirect_pc, m_pc);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
